pixel_argmax: RTL
=================

# pixel_argmax

Per-pixel classifier stage behind the output processing element. It consumes the stream of signed batch-normalized class scores, one score per cycle, `N_CLASS` consecutive scores per pixel in class order, and emits one class label per pixel. Each label carries its winning score and raster position flags. It sits between the final `PE_OUT` array and the label writer / frame DMA, and terminates the score interface.

## Interface
- `N_CLASS`, default 11: classes per pixel; legal range ≥ 2.
- `SCORE_WIDTH`, default 28: score width. Equals conv width 15 plus norm scale width 13.
- `IMG_W`, default 480: pixels per row.
- `IMG_H`, default 360: rows per frame.
- `LBL_WIDTH`, derived as `$clog2(N_CLASS)`: label width.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous soft clear.
- `s_valid` in 1: score beat valid.
- `s_ready` out 1: block accepts a beat.
- `s_score` in `SCORE_WIDTH`: two's-complement class score.
- `m_valid` out 1: label valid.
- `m_ready` in 1: downstream accepts the label.
- `m_label` out `LBL_WIDTH`: winning class index.
- `m_score` out `SCORE_WIDTH`: winning score.
- `m_last_col` out 1: pixel is the last in its row.
- `m_last_frame` out 1: pixel is the last in the frame.

## Operation
- Beat accepted iff `s_valid && s_ready`.
- Class counter `cls` runs 0..`N_CLASS`-1 and wraps to 0 after the final class.
- Running max:
  - At `cls==0`: `best<=s_score`, `idx<=0`.
  - Otherwise: update when `$signed(s_score) > $signed(best)`. The comparison is strict, so ties keep the lowest index.
- Final class beat (`cls==N_CLASS-1`):
  - The comparison including the current beat is evaluated combinationally.
  - Its result loads the output register: `m_label`, `m_score`, flags, and `m_valid<=1`.
- Output register holds its contents while `m_valid && !m_ready`. It clears when `m_valid && m_ready` and no new load occurs in the same cycle.
- `s_ready = !clr && !(cls==N_CLASS-1 && m_valid && !m_ready)`:
  - Non-final beats are never stalled.
  - The final beat waits for the output register to free up.
  - `s_ready` is combinational from `m_ready`.
- Position counters `col` (0..`IMG_W`-1) and `row` (0..`IMG_H`-1):
  - Advance on each final-class accept.
  - `col` wraps to 0 and increments `row`; `row` wraps to 0 after the last row.
- Flags captured with each label:
  - `m_last_col = (col==IMG_W-1)`.
  - `m_last_frame = m_last_col && (row==IMG_H-1)`.
- `clr` (synchronous, highest priority):
  - Zeroes `cls`, `col`, `row`, `best`, `idx` and `m_valid`.
  - A beat presented in the same cycle is not accepted, because `s_ready=0`.
- Scores are never saturated or re-scaled; full `SCORE_WIDTH` signed compare.

## Timing
- Reset values: `s_ready=1` once `rst_n` is high; `m_valid=0`, `m_label=0`, `m_score=0`, `m_last_col=0`, `m_last_frame=0`; all counters 0.
- Latency: label visible on `m_*` the cycle after the final class beat is accepted.
- Throughput: one label per `N_CLASS` cycles with no bubbles when `m_ready` stays high.
- Simultaneous drain and load (`m_valid && m_ready` plus final-beat accept): the new label replaces the old, `m_valid` stays 1, and nothing is lost.
- Back-pressure on a non-final beat: none. A partial pixel keeps accumulating even while the output is stalled.
- `rst_n` asserted mid-pixel or mid-frame: partial pixel discarded and outputs cleared immediately (asynchronous). The next accepted beat is class 0 of pixel (0,0).
- `m_*` are stable while `m_valid && !m_ready` (AXI-stream rules). `s_*` must be held by the source while `s_valid && !s_ready`.

## Structure
- Shared package `bcednet_pkg`:
  - Function `conv_out_width(D,FH,FW,NORMREF_WIDTH)`.
  - Constant `SCORE_WIDTH_DEF = conv_out_width(512,3,3,13)+13`.
  - Label-width helper.
  - Raster-counter typedef.
- One sub-module is natural: `raster_counter`, holding `col`/`row` with wrap and last flags. Reused by the label writer.
- Compare/max logic and the output register stay in `pixel_argmax`.

## Test plan
Bench runs at `N_CLASS=4`, `IMG_W=3`, `IMG_H=2`.
- Scores −5, 12, 7, 3 with `m_ready=1` → one cycle after the 4th beat `m_valid=1`, `m_label=1`, `m_score=12`, `m_last_col=0`.
- Tie 9, 9, −1, 9 → `m_label=0`, `m_score=9`. All-negative −8, −3, −3, −100 → `m_label=1`, `m_score=−3`.
- Stream 6 pixels back-to-back → 6 labels at a spacing of 4 cycles. `m_last_col` on pixels 2 and 5; `m_last_frame` only on pixel 5. Counters then wrap to (0,0).
- Hold `m_ready=0` after pixel 0 → beats 0–2 of pixel 1 accepted, `s_ready=0` on its final beat. Raise `m_ready` → pixel 0 drains, pixel 1 loads in the same cycle, no loss.
- Assert `rst_n=0` after 2 beats, then `clr` after 2 beats → outputs return to 0 and the next 4 beats form pixel (0,0). A beat coincident with `clr` is not accepted.
- Extremes `0x8000000` vs `0x7FFFFFF` → signed compare selects `0x7FFFFFF`.

Source files
------------

// File: rtl/bcednet_pkg.sv
// Shared BCEDNet constants, width helpers and raster position type.
package bcednet_pkg;

    localparam int unsigned RASTER_CNT_WIDTH = 16;

    // Signed popcount accumulator over D*FH*FW taps, widened to hold the norm reference, plus bias headroom.
    function automatic int unsigned conv_out_width(input int unsigned d, input int unsigned fh,
                                                   input int unsigned fw, input int unsigned normref_width);
        int unsigned acc_w;
        acc_w = $clog2(d * fh * fw + 1) + 1;
        return ((acc_w > normref_width) ? acc_w : normref_width) + 1;
    endfunction

    localparam int unsigned SCORE_WIDTH_DEF = conv_out_width(512, 3, 3, 13) + 13;

    function automatic int unsigned lbl_width(input int unsigned n_class);
        return (n_class < 2) ? 1 : $clog2(n_class);
    endfunction

    typedef struct packed {
        logic [RASTER_CNT_WIDTH-1:0] col;
        logic [RASTER_CNT_WIDTH-1:0] row;
    } raster_pos_t;

endpackage

// File: rtl/raster_counter.sv
// Column/row raster position tracker with wrap and end-of-row / end-of-frame flags.
module raster_counter
    import bcednet_pkg::*;
#(
    parameter int unsigned IMG_W = 480,
    parameter int unsigned IMG_H = 360
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic adv,
    output logic last_col_c,
    output logic last_frame_c
);

    localparam int unsigned CW = RASTER_CNT_WIDTH;

    raster_pos_t pos_q;

    assign last_col_c   = (pos_q.col == CW'(IMG_W - 1));
    assign last_frame_c = last_col_c && (pos_q.row == CW'(IMG_H - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= '0;
        end else if (clr) begin
            pos_q <= '0;
        end else if (adv) begin
            if (last_col_c) begin
                pos_q.col <= '0;
                pos_q.row <= last_frame_c ? '0 : pos_q.row + CW'(1);
            end else begin
                pos_q.col <= pos_q.col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pixel_argmax.sv
// Per-pixel argmax over N_CLASS streamed signed scores; emits one registered label per pixel.
module pixel_argmax
    import bcednet_pkg::*;
#(
    parameter int unsigned N_CLASS     = 11,
    parameter int unsigned SCORE_WIDTH = SCORE_WIDTH_DEF,
    parameter int unsigned IMG_W       = 480,
    parameter int unsigned IMG_H       = 360,
    localparam int unsigned LBL_WIDTH  = lbl_width(N_CLASS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [SCORE_WIDTH-1:0] s_score,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [LBL_WIDTH-1:0]   m_label,
    output logic [SCORE_WIDTH-1:0] m_score,
    output logic                   m_last_col,
    output logic                   m_last_frame
);

    logic [LBL_WIDTH-1:0]   cls;
    logic [LBL_WIDTH-1:0]   idx;
    logic [SCORE_WIDTH-1:0] best;

    logic                   final_c;
    logic                   accept_c;
    logic                   load_c;
    logic                   upd_c;
    logic [LBL_WIDTH-1:0]   win_label_c;
    logic [SCORE_WIDTH-1:0] win_score_c;
    logic                   last_col_c;
    logic                   last_frame_c;

    assign final_c  = (cls == LBL_WIDTH'(N_CLASS - 1));
    // Only the final beat waits on the output register; partial pixels keep flowing.
    assign s_ready  = !clr && !(final_c && m_valid && !m_ready);
    assign accept_c = s_valid && s_ready;
    assign load_c   = accept_c && final_c;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        upd_c       = 1'b0;
        win_label_c = idx;
        win_score_c = best;
        if (cls != '0 && $signed(s_score) > $signed(best)) begin
            upd_c       = 1'b1;
            win_label_c = cls;
            win_score_c = s_score;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls  <= '0;
            idx  <= '0;
            best <= '0;
        end else if (clr) begin
            cls  <= '0;
            idx  <= '0;
            best <= '0;
        end else if (accept_c) begin
            cls <= final_c ? '0 : cls + LBL_WIDTH'(1);
            if (cls == '0) begin
                best <= s_score;
                idx  <= '0;
            end else if (upd_c) begin
                best <= s_score;
                idx  <= cls;
            end
        end
    end

    // Output register: a new load wins over a same-cycle drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid      <= 1'b0;
            m_label      <= '0;
            m_score      <= '0;
            m_last_col   <= 1'b0;
            m_last_frame <= 1'b0;
        end else if (clr) begin
            m_valid      <= 1'b0;
            m_label      <= '0;
            m_score      <= '0;
            m_last_col   <= 1'b0;
            m_last_frame <= 1'b0;
        end else if (load_c) begin
            m_valid      <= 1'b1;
            m_label      <= win_label_c;
            m_score      <= win_score_c;
            m_last_col   <= last_col_c;
            m_last_frame <= last_frame_c;
        end else if (m_valid && m_ready) begin
            m_valid      <= 1'b0;
            m_label      <= '0;
            m_score      <= '0;
            m_last_col   <= 1'b0;
            m_last_frame <= 1'b0;
        end
    end

    raster_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_raster (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .adv          (load_c),
        .last_col_c   (last_col_c),
        .last_frame_c (last_frame_c)
    );

endmodule
